// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 decryptor: memory geometry and the PRGA state encoding.
package rc4_pkg;

   localparam int S_DEPTH = 256;
   localparam int MSG_MAX = 32;
   localparam int S_AW    = 8;
   localparam int MSG_AW  = 5;

   typedef enum logic [3:0] {
      PRGA_IDLE,
      PRGA_RD_I,
      PRGA_RD_I_W,
      PRGA_CAP_I,
      PRGA_RD_J,
      PRGA_RD_J_W,
      PRGA_CAP_J,
      PRGA_WR_I,
      PRGA_WR_J,
      PRGA_RD_F,
      PRGA_RD_F_W,
      PRGA_CAP_F,
      PRGA_WR_D,
      PRGA_DONE
   } prga_state_t;

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA stage: walks the permuted S RAM, generates one keystream byte per message byte
// and writes ciphertext XOR keystream into the decrypted-message RAM.
module rc4_prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = 32
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              done,
   output logic [S_AW-1:0]   s_addr,
   output logic [7:0]        s_wdata,
   output logic              s_wren,
   input  logic [7:0]        s_rdata,
   output logic [MSG_AW-1:0] e_addr,
   input  logic [7:0]        e_rdata,
   output logic [MSG_AW-1:0] d_addr,
   output logic [7:0]        d_wdata,
   output logic              d_wren
);

   localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

   prga_state_t       state;
   prga_state_t       next_state;
   logic [S_AW-1:0]   i;
   logic [S_AW-1:0]   j;
   logic [MSG_AW-1:0] k;
   logic [7:0]        si;
   logic [7:0]        sj;
   logic [7:0]        f;
   logic [7:0]        e;

   // Memories have a two-cycle read latency, hence the issue/wait/capture triplets.
   always_comb begin
      next_state = state;
      case (state)
         PRGA_IDLE:   if (start) next_state = PRGA_RD_I;
         PRGA_RD_I:   next_state = PRGA_RD_I_W;
         PRGA_RD_I_W: next_state = PRGA_CAP_I;
         PRGA_CAP_I:  next_state = PRGA_RD_J;
         PRGA_RD_J:   next_state = PRGA_RD_J_W;
         PRGA_RD_J_W: next_state = PRGA_CAP_J;
         PRGA_CAP_J:  next_state = PRGA_WR_I;
         PRGA_WR_I:   next_state = PRGA_WR_J;
         PRGA_WR_J:   next_state = PRGA_RD_F;
         PRGA_RD_F:   next_state = PRGA_RD_F_W;
         PRGA_RD_F_W: next_state = PRGA_CAP_F;
         PRGA_CAP_F:  next_state = PRGA_WR_D;
         PRGA_WR_D:   next_state = (k == LAST_K) ? PRGA_DONE : PRGA_RD_I;
         PRGA_DONE:   if (!start) next_state = PRGA_IDLE;
         default:     next_state = PRGA_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= PRGA_IDLE;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         si    <= '0;
         sj    <= '0;
         f     <= '0;
         e     <= '0;
      end else begin
         state <= next_state;
         case (state)
            PRGA_IDLE: begin
               if (start) begin
                  i <= '0;
                  j <= '0;
                  k <= '0;
               end
            end
            PRGA_RD_I: i <= i + 8'd1;
            PRGA_CAP_I: begin
               si <= s_rdata;
               j  <= j + s_rdata;
            end
            PRGA_CAP_J: sj <= s_rdata;
            PRGA_CAP_F: begin
               f <= s_rdata;
               e <= e_rdata;
            end
            PRGA_WR_D: if (k != LAST_K) k <= k + MSG_AW'(1);
            default: ;
         endcase
      end
   end

   // When i == j both swap writes hit the same address with the same value, so no special case.
   always_comb begin
      done    = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wren  = 1'b0;
      e_addr  = '0;
      d_addr  = '0;
      d_wdata = '0;
      d_wren  = 1'b0;
      case (state)
         PRGA_RD_I: s_addr = i + 8'd1;
         PRGA_RD_J: s_addr = j;
         PRGA_WR_I: begin
            s_addr  = i;
            s_wdata = sj;
            s_wren  = 1'b1;
         end
         PRGA_WR_J: begin
            s_addr  = j;
            s_wdata = si;
            s_wren  = 1'b1;
            e_addr  = k;
         end
         PRGA_RD_F: begin
            s_addr = si + sj;
            e_addr = k;
         end
         PRGA_WR_D: begin
            d_addr  = k;
            d_wdata = f ^ e;
            d_wren  = 1'b1;
         end
         PRGA_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: two instances (32-byte and 1-byte messages) sharing start/reset,
// each with its own S and D memories, compared against a plain RC4 PRGA model.
module tb_rc4_prga_decrypt;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       load_req;

   logic       done0, s0_wren, d0_wren;
   logic [7:0] s0_addr, s0_wdata, s0_rdata, e0_rdata, d0_wdata;
   logic [4:0] e0_addr, d0_addr;
   logic       done1, s1_wren, d1_wren;
   logic [7:0] s1_addr, s1_wdata, s1_rdata, e1_rdata, d1_wdata;
   logic [4:0] e1_addr, d1_addr;

   logic [7:0] s0_mem [256];
   logic [7:0] s1_mem [256];
   logic [7:0] d0_mem [32];
   logic [7:0] d1_mem [32];
   logic [7:0] e_rom  [32];
   logic [7:0] load_s [256];
   logic [7:0] exp_d  [32];
   logic [7:0] prev_d [32];
   logic [7:0] s0_aq, s1_aq;
   logic [4:0] e0_aq, e1_aq;

   int total;
   int bad;

   always #5 clk = ~clk;

   rc4_prga_decrypt #(.MSG_LEN(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .done(done0),
      .s_addr(s0_addr), .s_wdata(s0_wdata), .s_wren(s0_wren), .s_rdata(s0_rdata),
      .e_addr(e0_addr), .e_rdata(e0_rdata),
      .d_addr(d0_addr), .d_wdata(d0_wdata), .d_wren(d0_wren)
   );

   rc4_prga_decrypt #(.MSG_LEN(1)) dut_short (
      .clk(clk), .reset_n(reset_n), .start(start), .done(done1),
      .s_addr(s1_addr), .s_wdata(s1_wdata), .s_wren(s1_wren), .s_rdata(s1_rdata),
      .e_addr(e1_addr), .e_rdata(e1_rdata),
      .d_addr(d1_addr), .d_wdata(d1_wdata), .d_wren(d1_wren)
   );

   // Synchronous memories: address registered, data one edge later; writes land on the edge.
   always @(posedge clk) begin
      if (load_req) begin
         for (int x = 0; x < 256; x++) begin
            s0_mem[x] <= load_s[x];
            s1_mem[x] <= load_s[x];
         end
         for (int x = 0; x < 32; x++) begin
            d0_mem[x] <= 8'h00;
            d1_mem[x] <= 8'h00;
         end
      end else begin
         if (s0_wren) s0_mem[s0_addr] <= s0_wdata;
         if (s1_wren) s1_mem[s1_addr] <= s1_wdata;
         if (d0_wren) d0_mem[d0_addr] <= d0_wdata;
         if (d1_wren) d1_mem[d1_addr] <= d1_wdata;
      end
      s0_aq    <= s0_addr;
      s1_aq    <= s1_addr;
      e0_aq    <= e0_addr;
      e1_aq    <= e1_addr;
      s0_rdata <= s0_mem[s0_aq];
      s1_rdata <= s1_mem[s1_aq];
      e0_rdata <= e_rom[e0_aq];
      e1_rdata <= e_rom[e1_aq];
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Textbook RC4 PRGA over a private copy of S.
   task automatic compute_model(input int len);
      logic [7:0] s [256];
      logic [7:0] a, b, t, idx;
      for (int x = 0; x < 256; x++) s[x] = load_s[x];
      a = 8'd0;
      b = 8'd0;
      for (int n = 0; n < len; n++) begin
         a = a + 8'd1;
         b = b + s[a];
         t = s[a];
         s[a] = s[b];
         s[b] = t;
         idx = s[a] + s[b];
         exp_d[n] = s[idx] ^ e_rom[n];
      end
   endtask

   task automatic set_identity();
      for (int x = 0; x < 256; x++) load_s[x] = 8'(x);
   endtask

   task automatic build_ksa();
      logic [7:0] key [3];
      logic [7:0] b, t;
      key = '{8'h00, 8'h02, 8'h49};
      set_identity();
      b = 8'd0;
      for (int x = 0; x < 256; x++) begin
         b = b + load_s[x] + key[x % 3];
         t = load_s[x];
         load_s[x] = load_s[b];
         load_s[b] = t;
      end
   endtask

   task automatic build_random_perm();
      logic [7:0] t;
      int r;
      set_identity();
      for (int x = 255; x > 0; x--) begin
         r = $urandom_range(x, 0);
         t = load_s[x];
         load_s[x] = load_s[r];
         load_s[r] = t;
      end
   endtask

   task automatic apply_stimulus();
      load_req = 1'b1;
      @(posedge clk);
      #1 load_req = 1'b0;
   endtask

   task automatic wait_done(output int edges0, output int edges1, output int pulses0,
                            output int pulses1, output int order_err, output int first_addr);
      edges0 = 0; edges1 = 0; pulses0 = 0; pulses1 = 0; order_err = 0; first_addr = -1;
      while (done0 !== 1'b1 && edges0 < 2000) begin
         @(posedge clk);
         #1;
         edges0++;
         if (edges0 == 1) first_addr = int'(s0_addr);
         if (d0_wren === 1'b1) begin
            if (d0_addr !== 5'(pulses0)) order_err++;
            pulses0++;
         end
         if (d1_wren === 1'b1) pulses1++;
         if (done1 === 1'b1 && edges1 == 0) edges1 = edges0;
      end
   endtask

   task automatic check_run(input string name, input int edges0, input int edges1, input int pulses0,
                            input int pulses1, input int order_err, input int first_addr);
      check_output({name, "_latency"}, edges0, 385);
      check_output({name, "_short_latency"}, edges1, 13);
      check_output({name, "_d_wren_count"}, pulses0, 32);
      check_output({name, "_short_d_wren_count"}, pulses1, 1);
      check_output({name, "_d_addr_order"}, order_err, 0);
      check_output({name, "_first_s_addr"}, first_addr, 1);
      for (int x = 0; x < 32; x++)
         check_output($sformatf("%s_d%0d", name, x), 32'(d0_mem[x]), 32'(exp_d[x]));
      check_output({name, "_short_d0"}, 32'(d1_mem[0]), 32'(exp_d[0]));
   endtask

   task automatic run_scenario(input string name);
      int e0, e1, p0, p1, oe, fa;
      apply_stimulus();
      compute_model(32);
      @(posedge clk);
      #1 start = 1'b1;
      wait_done(e0, e1, p0, p1, oe, fa);
      check_run(name, e0, e1, p0, p1, oe, fa);
   endtask

   task automatic end_run(input string name);
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      check_output({name, "_done_drop"}, 32'(done0), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: summary not reached in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int held;
      int e0, e1, p0, p1, oe, fa;
      logic [7:0] inv;
      total    = 0;
      bad      = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      load_req = 1'b0;
      for (int x = 0; x < 32; x++) e_rom[x] = 8'h00;
      set_identity();
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_done", 32'(done0), 32'd0);
      check_output("rst_s_wren", 32'(s0_wren), 32'd0);
      check_output("rst_d_wren", 32'(d0_wren), 32'd0);
      check_output("rst_s_addr", 32'(s0_addr), 32'd0);
      check_output("rst_e_addr", 32'(e0_addr), 32'd0);
      check_output("rst_d_wdata", 32'(d0_wdata), 32'd0);
      reset_n = 1'b1;

      // Identity S, zero ciphertext: D is the raw keystream.
      run_scenario("ident");
      check_output("ident_d0_const", 32'(d0_mem[0]), 32'h02);
      check_output("ident_d1_const", 32'(d0_mem[1]), 32'h05);
      check_output("ident_d2_const", 32'(d0_mem[2]), 32'h07);
      for (int x = 0; x < 32; x++) prev_d[x] = d0_mem[x];
      held = 0;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk);
         #1;
         if (d0_wren || d1_wren || s0_wren || s1_wren) held++;
      end
      check_output("hold_no_rerun", held, 0);
      check_output("hold_done", 32'(done0), 32'd1);
      end_run("ident");

      // Identity S, all-ones ciphertext: every byte inverts.
      for (int x = 0; x < 32; x++) e_rom[x] = 8'hFF;
      set_identity();
      run_scenario("invert");
      for (int x = 0; x < 32; x++) begin
         inv = ~prev_d[x];
         check_output($sformatf("invert_vs_prev%0d", x), 32'(d0_mem[x]), 32'(inv));
      end
      end_run("invert");

      // S from key 0x000249, random ciphertext.
      for (int x = 0; x < 32; x++) e_rom[x] = 8'($urandom);
      build_ksa();
      run_scenario("ksa");
      end_run("ksa");

      // Random permutations and random ciphertext.
      for (int t = 0; t < 2; t++) begin
         for (int x = 0; x < 32; x++) e_rom[x] = 8'($urandom);
         build_random_perm();
         run_scenario($sformatf("rand%0d", t));
         end_run($sformatf("rand%0d", t));
      end

      // Abort during WR_I of byte 5, then restart from a fresh S.
      for (int x = 0; x < 32; x++) e_rom[x] = 8'h00;
      set_identity();
      apply_stimulus();
      @(posedge clk);
      #1 start = 1'b1;
      repeat (67) @(posedge clk);
      #1;
      check_output("abort_in_wr_i", 32'(s0_wren), 32'd1);
      check_output("abort_wr_i_addr", 32'(s0_addr), 32'd6);
      reset_n = 1'b0;
      #1;
      check_output("abort_done", 32'(done0), 32'd0);
      check_output("abort_s_wren", 32'(s0_wren), 32'd0);
      check_output("abort_d_wren", 32'(d0_wren), 32'd0);
      check_output("abort_s_addr", 32'(s0_addr), 32'd0);
      apply_stimulus();
      compute_model(32);
      reset_n = 1'b1;
      wait_done(e0, e1, p0, p1, oe, fa);
      check_run("restart", e0, e1, p0, p1, oe, fa);
      end_run("restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rc4_prga_decrypt.md
# rc4_prga_decrypt

RC4 keystream generator and decryptor (PRGA stage) for the RC4 decryptor. It runs after the key-scheduling stage has left a permuted S array in the 256×8 S RAM. It reads MSG_LEN ciphertext bytes from the encrypted-message ROM, XORs each one with the generated keystream byte, and writes the plaintext into the 32×8 decrypted-message RAM. That RAM is then scanned by the downstream plaintext checker (fetches by `address_d`, raises `error`/`finished`).

## Interface
Parameters:
- `MSG_LEN`, default 32: message length in bytes; legal range 1..32.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level request from the key-search controller.
- `done`, out, 1: high while in state DONE.
- `s_addr`, out, 8: S RAM address.
- `s_wdata`, out, 8: S RAM write data.
- `s_wren`, out, 1: S RAM write enable.
- `s_rdata`, in, 8: S RAM read data.
- `e_addr`, out, 5: encrypted ROM address.
- `e_rdata`, in, 8: encrypted ROM data.
- `d_addr`, out, 5: decrypted RAM address.
- `d_wdata`, out, 8: decrypted RAM write data.
- `d_wren`, out, 1: decrypted RAM write enable.

## Operation
- Algorithm:
  - Start with i=0, j=0.
  - For each k in 0..MSG_LEN-1:
    - i=i+1; j=j+S[i]; swap S[i], S[j].
    - f=S[S[i]+S[j]]; D[k]=f^E[k].
  - All index and sum arithmetic is 8-bit and wraps modulo 256. k is 5 bits.
- Memory model, all three memories: address, wren and wdata are sampled at a rising edge. A read needs an issue state, then one wait state; `*_rdata` is captured in the third state.
- FSM states; each state lasts one cycle, except IDLE and DONE:
  - IDLE: on `start`=1, clear i, j, k; go to RD_I.
  - RD_I: `s_addr`=i+1; i<=i+1.
  - RD_I_W.
  - CAP_I: si<=`s_rdata`; j<=j+`s_rdata`.
  - RD_J: `s_addr`=j.
  - RD_J_W.
  - CAP_J: sj<=`s_rdata`.
  - WR_I: `s_addr`=i, `s_wdata`=sj, `s_wren`=1.
  - WR_J: `s_addr`=j, `s_wdata`=si, `s_wren`=1; `e_addr`=k.
  - RD_F: `s_addr`=si+sj; `e_addr`=k.
  - RD_F_W.
  - CAP_F: f<=`s_rdata`; e<=`e_rdata`.
  - WR_D: `d_addr`=k, `d_wdata`=f^e, `d_wren`=1.
    - If k==MSG_LEN-1, go to DONE.
    - Otherwise k<=k+1 and go to RD_I.
  - DONE: `done`=1; return to IDLE when `start`=0.
- Case i==j: both writes target the same address with the same value. No special handling is needed.
- Read-after-write: the WR_J write completes before the RD_F address is sampled, so no bypass is required.
- `start` is level-sensitive:
  - Deasserting `start` mid-run is ignored; the run completes.
  - Holding `start` high in DONE does not re-trigger. A new run requires `start`=0, then 1.
- S is not restored between runs. A rerun continues from the swapped S; the controller reruns key scheduling first.

## Timing
- Reset (async, immediate) puts the FSM in IDLE and sets:
  - i, j, k, si, sj, f, e = 0;
  - `done`=0, all wren=0, all addr/wdata=0.
- In non-write states, wren=0 and addr/wdata=0. Exceptions: `s_addr` in read states and `e_addr` in WR_J/RD_F.
- Per byte: 12 cycles.
- Latency: `done` rises 12*MSG_LEN+1 rising edges after the edge that samples `start`=1 in IDLE. With the default MSG_LEN this is 385.
- `d_wren` pulses exactly MSG_LEN times, one cycle each, with `d_addr` in order 0..MSG_LEN-1.
- `reset_n` low mid-run aborts immediately. Partial writes to S and D remain; no recovery is attempted.

## Structure
- Shared package `rc4_pkg` holds:
  - the PRGA state enum;
  - constants S_DEPTH=256 and MSG_MAX=32;
  - address-width localparams S_AW=8 and MSG_AW=5 (also used by the key-scheduling stage and the checker).
- Single module, no sub-module.
- Output decode is combinational from state plus registers. All datapath registers sit in one async-reset always_ff.

## Test plan
- Identity S (S[x]=x), E all zero, MSG_LEN=32 → D[0]=0x02, D[1]=0x05, D[2]=0x07; all 32 bytes match the behavioural model. D[0] also covers the i==j swap case at i=j=1.
- Identity S, E[k]=0xFF → every D[k] is the bitwise inverse of the previous scenario's value.
- Known key: S preloaded from a model KSA with key 0x000249 and E = the course ciphertext → D equals the model plaintext. This output fed to the checker gives `finished`=1, `error`=0.
- Timing: `start` at edge t → `done` at t+385; `d_wren` asserted 32 times with `d_addr` 0..31. Holding `start` high for 50 extra cycles → no second run. Dropping `start` → IDLE next cycle.
- Reset mid-run: `reset_n`=0 during WR_I of byte 5 → `done`=0, FSM in IDLE, all wren=0 at once. After release with `start` high, a run starts with i=j=k=0.
- MSG_LEN=1 → exactly one `d_wren`; `done` at 13 cycles after start.
